// File: rtl/counter_seq_ctrl.sv
// Command sequencer for an external up-counter: accepts START/STOP/CLEAR,
// paces increments with a prescaler and handles the terminal count.
module counter_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [PRE_W-1:0] cfg_prescale,
    input  logic             cfg_oneshot,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_inc,
    output logic             cnt_clr,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_CLR  = 2'b11
    } state_t;

    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t             state_r, state_nxt_s;
    logic [PRE_W-1:0]   pre_cnt_r, pre_cnt_nxt_s;
    logic [WIDTH-1:0]   lim_r, lim_nxt_s;
    logic [PRE_W-1:0]   pre_r, pre_nxt_s;
    logic               os_r, os_nxt_s;
    logic               accept_s;
    logic               tick_s;
    logic               done_s;

    assign accept_s  = cmd_valid & cmd_ready;
    assign tick_s    = (state_r == ST_RUN) && (pre_cnt_r == pre_r);
    assign done_s    = tick_s && (cnt_q == lim_r);

    // Strobes derive from registered state so a command never alters the current cycle.
    assign cnt_inc   = tick_s && (cnt_q != lim_r);
    assign done      = done_s;
    assign cnt_clr   = done_s || (state_r == ST_CLR);
    assign busy      = (state_r != ST_IDLE);
    assign cmd_ready = (state_r != ST_CLR);
    assign state     = state_r;

    // Next-state, prescaler and configuration-latch logic.
    always_comb begin
        state_nxt_s   = state_r;
        pre_cnt_nxt_s = pre_cnt_r;
        lim_nxt_s     = lim_r;
        pre_nxt_s     = pre_r;
        os_nxt_s      = os_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (cmd_op == OP_START)) begin
                    state_nxt_s   = ST_RUN;
                    lim_nxt_s     = cfg_limit;
                    pre_nxt_s     = cfg_prescale;
                    os_nxt_s      = cfg_oneshot;
                    pre_cnt_nxt_s = {PRE_W{1'b0}};
                end else if (accept_s && (cmd_op == OP_CLEAR)) begin
                    state_nxt_s = ST_CLR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // The prescaler still advances on the cycle a STOP/CLEAR is accepted.
                if (tick_s) begin
                    pre_cnt_nxt_s = {PRE_W{1'b0}};
                end else begin
                    pre_cnt_nxt_s = pre_cnt_r + {{(PRE_W-1){1'b0}}, 1'b1};
                end
                if (accept_s && (cmd_op == OP_CLEAR)) begin
                    state_nxt_s = ST_CLR;
                end else if (done_s && os_r) begin
                    state_nxt_s   = ST_IDLE;
                    pre_cnt_nxt_s = {PRE_W{1'b0}};
                end else if (accept_s && (cmd_op == OP_STOP)) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (accept_s && (cmd_op == OP_START)) begin
                    state_nxt_s = ST_RUN;
                end else if (accept_s && (cmd_op == OP_CLEAR)) begin
                    state_nxt_s = ST_CLR;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_CLR: begin
                state_nxt_s   = ST_IDLE;
                pre_cnt_nxt_s = {PRE_W{1'b0}};
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                pre_cnt_nxt_s = {PRE_W{1'b0}};
            end
        endcase
    end

    // State and configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            pre_cnt_r <= {PRE_W{1'b0}};
            lim_r     <= {WIDTH{1'b0}};
            pre_r     <= {PRE_W{1'b0}};
            os_r      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pre_cnt_r <= pre_cnt_nxt_s;
            lim_r     <= lim_nxt_s;
            pre_r     <= pre_nxt_s;
            os_r      <= os_nxt_s;
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: vector table plus hand-written
// sequences for hold/resume, clear timing and asynchronous reset.
module tb_counter_seq_ctrl;

    localparam logic [1:0] NOP = 2'b00, START = 2'b01, STOP = 2'b10, CLEAR = 2'b11;
    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_HOLD = 2'b10, S_CLR = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cfg_limit;
    logic [7:0] cfg_prescale;
    logic       cfg_oneshot;
    logic [3:0] cnt_q;
    logic       cnt_inc, cnt_clr, done, busy;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    counter_seq_ctrl #(.WIDTH(4), .PRE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cfg_limit(cfg_limit), .cfg_prescale(cfg_prescale),
        .cfg_oneshot(cfg_oneshot), .cnt_q(cnt_q), .cnt_inc(cnt_inc), .cnt_clr(cnt_clr),
        .done(done), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    // External counter register driven by the strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt_q <= 4'd0;
        else if (cnt_clr) cnt_q <= 4'd0;
        else if (cnt_inc) cnt_q <= cnt_q + 4'd1;
    end

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [3:0] lim;
        logic [7:0] pre;
        logic       os;
        logic       e_inc, e_clr, e_done, e_busy;
        logic [1:0] e_st;
        logic       e_rdy;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic v, logic [1:0] op, logic [3:0] lim, logic [7:0] pre,
                                logic os, logic inc, logic clr, logic dn, logic bsy,
                                logic [1:0] st, logic rdy);
        vec_t r;
        r.v = v; r.op = op; r.lim = lim; r.pre = pre; r.os = os;
        r.e_inc = inc; r.e_clr = clr; r.e_done = dn; r.e_busy = bsy; r.e_st = st; r.e_rdy = rdy;
        return r;
    endfunction

    task automatic cmp(string nm, logic [1:0] act, logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk(string nm, logic inc, logic clr, logic dn, logic bsy,
                       logic [1:0] st, logic rdy);
        cmp({nm, ".inc"},   {1'b0, cnt_inc},   {1'b0, inc});
        cmp({nm, ".clr"},   {1'b0, cnt_clr},   {1'b0, clr});
        cmp({nm, ".done"},  {1'b0, done},      {1'b0, dn});
        cmp({nm, ".busy"},  {1'b0, busy},      {1'b0, bsy});
        cmp({nm, ".state"}, state,             st);
        cmp({nm, ".ready"}, {1'b0, cmd_ready}, {1'b0, rdy});
    endtask

    task automatic drv(logic v, logic [1:0] op, logic [3:0] lim, logic [7:0] pre, logic os);
        cmd_valid = v; cmd_op = op; cfg_limit = lim; cfg_prescale = pre; cfg_oneshot = os;
    endtask

    initial begin
        // Free-running lim=3 pre=0, CLEAR on a done cycle, then one-shot lim=1 pre=2.
        vecs[0]  = mk(1'b1, START, 4'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);
        vecs[1]  = mk(1'b0, NOP,   4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_RUN,  1'b1);
        vecs[2]  = mk(1'b1, NOP,   4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_RUN,  1'b1);
        vecs[3]  = mk(1'b0, NOP,   4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_RUN,  1'b1);
        vecs[4]  = mk(1'b0, NOP,   4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, S_RUN,  1'b1);
        vecs[5]  = mk(1'b0, NOP,   4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_RUN,  1'b1);
        vecs[6]  = mk(1'b0, NOP,   4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_RUN,  1'b1);
        vecs[7]  = mk(1'b0, NOP,   4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_RUN,  1'b1);
        vecs[8]  = mk(1'b1, CLEAR, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, S_RUN,  1'b1);
        vecs[9]  = mk(1'b0, NOP,   4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S_CLR,  1'b0);
        vecs[10] = mk(1'b1, START, 4'd1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);
        vecs[11] = mk(1'b0, NOP,   4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_RUN,  1'b1);
        vecs[12] = mk(1'b0, NOP,   4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_RUN,  1'b1);
        vecs[13] = mk(1'b0, NOP,   4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_RUN,  1'b1);
        vecs[14] = mk(1'b0, NOP,   4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_RUN,  1'b1);
        vecs[15] = mk(1'b0, NOP,   4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_RUN,  1'b1);
        vecs[16] = mk(1'b0, NOP,   4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, S_RUN,  1'b1);
        vecs[17] = mk(1'b1, STOP,  4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);
        vecs[18] = mk(1'b0, NOP,   4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);

        // Reset held with a command offered.
        rst_n = 1'b0;
        drv(1'b1, START, 4'd5, 8'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset", 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);
        end
        drv(1'b0, NOP, 4'd0, 8'd0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d", i), vecs[i].e_inc, vecs[i].e_clr, vecs[i].e_done,
                vecs[i].e_busy, vecs[i].e_st, vecs[i].e_rdy);
            drv(vecs[i].v, vecs[i].op, vecs[i].lim, vecs[i].pre, vecs[i].os);
        end

        // Hold/resume: lim=7 pre=3, STOP at cycle 5, new cfg ignored on resume.
        @(negedge clk);
        chk("hold.c0", 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);
        drv(1'b1, START, 4'd7, 8'd3, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c <= 5) chk($sformatf("hold.c%0d", c), c == 4, 1'b0, 1'b0, 1'b1, S_RUN, 1'b1);
            else        chk($sformatf("hold.c%0d", c), 1'b0, 1'b0, 1'b0, 1'b1, S_HOLD, 1'b1);
            if (c == 5)       drv(1'b1, STOP, cfg_limit, cfg_prescale, cfg_oneshot);
            else if (c >= 7 && c < 15) drv(1'b0, NOP, 4'd2, 8'd0, 1'b1);
            else if (c == 15) drv(1'b1, START, 4'd2, 8'd0, 1'b1);
            else              drv(1'b0, NOP, cfg_limit, cfg_prescale, cfg_oneshot);
        end
        for (int c = 16; c <= 43; c++) begin
            @(negedge clk);
            chk($sformatf("resume.c%0d", c), (c >= 18) && ((c - 18) % 4 == 0) && (c != 42),
                c == 42, c == 42, 1'b1, S_RUN, 1'b1);
            if (c == 43) drv(1'b1, CLEAR, 4'd0, 8'd0, 1'b0);
            else         drv(1'b0, NOP, 4'd0, 8'd0, 1'b0);
        end
        @(negedge clk);
        chk("hold.clr", 1'b0, 1'b1, 1'b0, 1'b1, S_CLR, 1'b0);
        drv(1'b0, NOP, 4'd0, 8'd0, 1'b0);

        // CLEAR accepted on an increment cycle; START during CLR is refused.
        @(negedge clk);
        chk("clrinc.c0", 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);
        drv(1'b1, START, 4'd3, 8'd0, 1'b0);
        @(negedge clk);
        chk("clrinc.c1", 1'b1, 1'b0, 1'b0, 1'b1, S_RUN, 1'b1);
        drv(1'b0, NOP, 4'd0, 8'd0, 1'b0);
        @(negedge clk);
        chk("clrinc.c2", 1'b1, 1'b0, 1'b0, 1'b1, S_RUN, 1'b1);
        drv(1'b1, CLEAR, 4'd0, 8'd0, 1'b0);
        @(negedge clk);
        chk("clrinc.c3", 1'b0, 1'b1, 1'b0, 1'b1, S_CLR, 1'b0);
        drv(1'b1, START, 4'd3, 8'd0, 1'b0);
        @(negedge clk);
        chk("clrinc.c4", 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);
        cmp("clrinc.cnt", {2'b00} | cnt_q[1:0], 2'b00);
        drv(1'b0, NOP, 4'd0, 8'd0, 1'b0);
        @(negedge clk);
        chk("clrinc.c5", 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);

        // Asynchronous reset mid-RUN, then lim=0 pre=0 gives done every cycle.
        drv(1'b1, START, 4'd3, 8'd0, 1'b0);
        @(negedge clk);
        chk("arst.run", 1'b1, 1'b0, 1'b0, 1'b1, S_RUN, 1'b1);
        drv(1'b0, NOP, 4'd0, 8'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("arst.async", 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);
        @(negedge clk);
        chk("arst.held", 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        drv(1'b1, START, 4'd0, 8'd0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("lim0.c%0d", c), 1'b0, 1'b1, 1'b1, 1'b1, S_RUN, 1'b1);
            drv(1'b0, NOP, 4'd0, 8'd0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
